// File: rtl/img_conv_engine_pkg.sv
// Shared widths, FSM state type and output saturation for the 3x3 convolution engine.
package img_conv_pkg;

  localparam int PIX_W   = 8;
  localparam int ADDR_W  = 8;
  localparam int COEFF_W = 8;
  localparam int ACC_W   = 20;
  localparam int NTAPS   = 9;

  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'(2**PIX_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    PIX,
    READ,
    DRAIN,
    WRITE,
    DONE
  } conv_state_t;

  // Arithmetic shift of the signed sum, then clamp into the unsigned pixel range.
  function automatic logic [PIX_W-1:0] sat_pix(input logic signed [ACC_W-1:0] acc,
                                               input logic [3:0]              shift);
    logic signed [ACC_W-1:0] s;
    s = acc >>> shift;
    if (s < 0)       return '0;
    if (s > PIX_MAX) return '1;
    return s[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/img_conv_engine_if.sv
// Single-port image SRAM connection: row/col address, write strobe, sense enable, data in/out.
interface img_sram_intf import img_conv_pkg::*; ();

  logic              write_en;
  logic              sense_en;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;
  logic [PIX_W-1:0]  din;
  logic [PIX_W-1:0]  dout;

  modport mst (output write_en, sense_en, row, col, din, input dout);
  modport slv (input write_en, sense_en, row, col, din, output dout);

endinterface

// File: rtl/img_conv_engine_mac.sv
// Signed multiply-accumulate for one 3x3 window, with a saturated view of the next sum.
module img_conv_mac import img_conv_pkg::*; (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clr,
  input  logic                      acc_en,
  input  logic [PIX_W-1:0]          pix,
  input  logic signed [COEFF_W-1:0] coeff,
  input  logic [3:0]                shift,
  output logic [PIX_W-1:0]          pix_next
);

  localparam int PROD_W = PIX_W + 1 + COEFF_W;

  logic signed [PIX_W:0]       pix_s;
  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_W-1:0]     acc_q, acc_d;

  // NOTE: always_comb uses blocking (=) assignments; always_ff uses non-blocking (<=) only.
  always_comb begin
    pix_s = {1'b0, pix};
    prod  = pix_s * coeff;
    acc_d = acc_q;
    if (clr)         acc_d = '0;
    else if (acc_en) acc_d = acc_q + ACC_W'(prod);
  end

  // The output register downstream samples the sum including this cycle's product.
  assign pix_next = sat_pix(acc_d, shift);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/img_conv_engine.sv
// 3x3 convolution from a source image SRAM into a destination SRAM; FSM, counters, addressing.
module img_conv_engine import img_conv_pkg::*; (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic [ADDR_W-1:0]      nrows,
  input  logic [ADDR_W-1:0]      ncols,
  input  logic [9*COEFF_W-1:0]   coeffs,
  input  logic [3:0]             shift,
  output logic                   busy,
  output logic                   done,
  img_sram_intf.mst              sram_src,
  img_sram_intf.mst              sram_dst
);

  conv_state_t                     state_q, state_d;
  logic [ADDR_W-1:0]               r_q, r_d, c_q, c_d;
  logic [ADDR_W-1:0]               nrows_q, nrows_d, ncols_q, ncols_d;
  logic [NTAPS-1:0][COEFF_W-1:0]   coeffs_q, coeffs_d;
  logic [3:0]                      shift_q, shift_d;
  logic [3:0]                      k_q, k_d;
  logic                            busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0]               src_row_q, src_row_d, src_col_q, src_col_d;
  logic                            dst_we_q, dst_we_d;
  logic [ADDR_W-1:0]               dst_row_q, dst_row_d, dst_col_q, dst_col_d;
  logic [PIX_W-1:0]                dst_din_q, dst_din_d;

  logic                            mac_clr, mac_acc_en, enter_pix, border;
  logic [3:0]                      mac_k, dr, dc;
  logic [PIX_W-1:0]                mac_pix;

  img_conv_mac u_mac (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (mac_clr),
    .acc_en   (mac_acc_en),
    .pix      (sram_src.dout),
    .coeff    (coeffs_q[mac_k]),
    .shift    (shift_q),
    .pix_next (mac_pix)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d    = state_q;
    r_d        = r_q;
    c_d        = c_q;
    nrows_d    = nrows_q;
    ncols_d    = ncols_q;
    coeffs_d   = coeffs_q;
    shift_d    = shift_q;
    k_d        = k_q;
    mac_clr    = 1'b0;
    mac_acc_en = 1'b0;
    mac_k      = k_q - 4'd1;
    enter_pix  = 1'b0;
    border     = 1'b0;
    dr         = '0;
    dc         = '0;
    src_row_d  = '0;
    src_col_d  = '0;
    dst_we_d   = 1'b0;
    dst_row_d  = '0;
    dst_col_d  = '0;
    dst_din_d  = '0;

    case (state_q)
      IDLE: begin
        if (en) begin
          nrows_d  = nrows;
          ncols_d  = ncols;
          coeffs_d = coeffs;
          shift_d  = shift;
          r_d      = '0;
          c_d      = '0;
          if (nrows == '0 || ncols == '0) state_d = DONE;
          else                            enter_pix = 1'b1;
        end
      end
      READ: begin
        // Data for tap k-1 arrives now; k runs to 9 so DRAIN picks up tap 8.
        mac_acc_en = (k_q != 4'd0);
        k_d        = k_q + 4'd1;
        if (k_q == 4'd8) state_d = DRAIN;
      end
      DRAIN: begin
        mac_acc_en = 1'b1;
        state_d    = WRITE;
      end
      WRITE: begin
        if (c_q == ncols_q - ADDR_W'(1)) begin
          c_d = '0;
          if (r_q == nrows_q - ADDR_W'(1)) begin
            state_d = DONE;
          end else begin
            r_d       = r_q + ADDR_W'(1);
            enter_pix = 1'b1;
          end
        end else begin
          c_d       = c_q + ADDR_W'(1);
          enter_pix = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // PIX is a decision, not a resting state: it resolves straight into WRITE or READ.
    if (enter_pix) begin
      border  = (r_d == '0) || (c_d == '0) ||
                (r_d == nrows_d - ADDR_W'(1)) || (c_d == ncols_d - ADDR_W'(1));
      state_d = border ? WRITE : READ;
      k_d     = '0;
      mac_clr = !border;
    end

    if (state_d == READ) begin
      dr        = k_d / 4'd3;
      dc        = k_d - dr * 4'd3;
      src_row_d = r_d + ADDR_W'(dr) - ADDR_W'(1);
      src_col_d = c_d + ADDR_W'(dc) - ADDR_W'(1);
    end

    if (state_d == WRITE) begin
      dst_we_d  = 1'b1;
      dst_row_d = r_d;
      dst_col_d = c_d;
      dst_din_d = (state_q == DRAIN) ? mac_pix : '0;
    end

    busy_d = state_d inside {READ, DRAIN, WRITE};
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      r_q       <= '0;
      c_q       <= '0;
      nrows_q   <= '0;
      ncols_q   <= '0;
      coeffs_q  <= '0;
      shift_q   <= '0;
      k_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      src_row_q <= '0;
      src_col_q <= '0;
      dst_we_q  <= 1'b0;
      dst_row_q <= '0;
      dst_col_q <= '0;
      dst_din_q <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      c_q       <= c_d;
      nrows_q   <= nrows_d;
      ncols_q   <= ncols_d;
      coeffs_q  <= coeffs_d;
      shift_q   <= shift_d;
      k_q       <= k_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      src_row_q <= src_row_d;
      src_col_q <= src_col_d;
      dst_we_q  <= dst_we_d;
      dst_row_q <= dst_row_d;
      dst_col_q <= dst_col_d;
      dst_din_q <= dst_din_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign sram_src.write_en = 1'b0;
  assign sram_src.sense_en = 1'b1;
  assign sram_src.row      = src_row_q;
  assign sram_src.col      = src_col_q;
  assign sram_src.din      = '0;
  assign sram_dst.write_en = dst_we_q;
  assign sram_dst.sense_en = 1'b1;
  assign sram_dst.row      = dst_row_q;
  assign sram_dst.col      = dst_col_q;
  assign sram_dst.din      = dst_din_q;

endmodule

// File: tb/tb_img_conv_engine.sv
// Scoreboard bench for img_conv_engine: a reference convolution queues expected writes, a monitor checks them.
module tb_img_conv_engine;

  typedef int kern_t[9];
  typedef struct {
    int r;
    int c;
    int v;
  } wr_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [7:0]  nrows, ncols;
  logic [71:0] coeffs;
  logic [3:0]  shift;
  logic        busy, done;

  img_sram_intf src_if ();
  img_sram_intf dst_if ();

  img_conv_engine dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .nrows    (nrows),
    .ncols    (ncols),
    .coeffs   (coeffs),
    .shift    (shift),
    .busy     (busy),
    .done     (done),
    .sram_src (src_if),
    .sram_dst (dst_if)
  );

  always #5 clk = ~clk;

  logic [7:0] src_mem [256][256];

  // Source SRAM: registered read, data visible the cycle after the address.
  always @(posedge clk)
    if (src_if.sense_en && !src_if.write_en)
      src_if.dout <= src_mem[src_if.row][src_if.col];

  assign dst_if.dout = '0;

  wr_t exp_q[$];
  int  n_checks    = 0;
  int  n_pass      = 0;
  int  busy_cycles = 0;
  int  done_cycles = 0;
  bit  src_we_seen = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: pops one expected write per observed dst write.
  always @(negedge clk) begin
    if (rstn) begin
      if (busy) busy_cycles++;
      if (done) done_cycles++;
      if (src_if.write_en) src_we_seen = 1'b1;
      if (dst_if.write_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check($sformatf("wr_addr(%0d,%0d)", e.r, e.c),
                int'(dst_if.row) * 256 + int'(dst_if.col), e.r * 256 + e.c);
          check($sformatf("wr_data(%0d,%0d)", e.r, e.c), int'(dst_if.din), e.v);
        end
      end
    end
  end

  function automatic bit is_border(input int r, input int c, input int nr, input int nc);
    return (r == 0) || (c == 0) || (r == nr - 1) || (c == nc - 1);
  endfunction

  function automatic int ref_pix(input int r, input int c, input int nr, input int nc,
                                 input kern_t k, input int sh);
    int acc;
    if (is_border(r, c, nr, nc)) return 0;
    acc = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        acc += k[3*dr + dc] * int'(src_mem[r-1+dr][c-1+dc]);
    acc = acc >>> sh;
    if (acc < 0)   return 0;
    if (acc > 255) return 255;
    return acc;
  endfunction

  task automatic fill_ramp(input int nr, input int nc);
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++)
        src_mem[r][c] = 8'(r * nc + c);
  endtask

  task automatic fill_const(input int nr, input int nc, input int v);
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++)
        src_mem[r][c] = 8'(v);
  endtask

  task automatic fill_rand(input int nr, input int nc);
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++)
        src_mem[r][c] = 8'($urandom_range(0, 255));
  endtask

  task automatic rand_kern(output kern_t k);
    for (int i = 0; i < 9; i++) begin
      int v;
      v = int'($urandom_range(0, 255));
      k[i] = (v > 127) ? v - 256 : v;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},      int'(busy), 0);
    check({tag, "_done"},      int'(done), 0);
    check({tag, "_src_we"},    int'(src_if.write_en), 0);
    check({tag, "_dst_we"},    int'(dst_if.write_en), 0);
    check({tag, "_src_sense"}, int'(src_if.sense_en), 1);
    check({tag, "_dst_sense"}, int'(dst_if.sense_en), 1);
    check({tag, "_src_addr"},  int'(src_if.row) * 256 + int'(src_if.col), 0);
    check({tag, "_dst_addr"},  int'(dst_if.row) * 256 + int'(dst_if.col), 0);
    check({tag, "_src_din"},   int'(src_if.din), 0);
    check({tag, "_dst_din"},   int'(dst_if.din), 0);
  endtask

  // Called at posedge+1. glitch_at pulses en mid-frame; abort_at drops rstn mid-frame.
  task automatic run_frame(input int nr, input int nc, input kern_t k, input int sh,
                           input int glitch_at, input int abort_at);
    int          cost;
    int          lat;
    int          b0, d0;
    logic [71:0] cw;
    for (int i = 0; i < 9; i++) cw[8*i +: 8] = 8'(k[i]);
    cost = 0;
    if (nr > 0 && nc > 0)
      for (int r = 0; r < nr; r++)
        for (int c = 0; c < nc; c++) begin
          exp_q.push_back('{r, c, ref_pix(r, c, nr, nc, k, sh)});
          cost += is_border(r, c, nr, nc) ? 1 : 11;
        end
    b0          = busy_cycles;
    d0          = done_cycles;
    src_we_seen = 1'b0;
    nrows  = 8'(nr);
    ncols  = 8'(nc);
    coeffs = cw;
    shift  = 4'(sh);
    en     = 1'b1;
    @(posedge clk); #1;
    en     = 1'b0;
    nrows  = 8'($urandom);
    ncols  = 8'($urandom);
    coeffs = {8'($urandom), 32'($urandom), 32'($urandom)};
    shift  = 4'($urandom);
    lat    = 0;
    while (!done && lat < 20000) begin
      if (lat == abort_at) begin
        check("busy_before_abort", int'(busy), 1);
        #2 rstn = 1'b0;
        #1 check_idle("abort");
        exp_q.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        return;
      end
      if (lat == glitch_at) en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      lat++;
    end
    check("done_latency", lat, cost);
    @(posedge clk); #1;
    check("done_one_cycle", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
    check("busy_cycles", busy_cycles - b0, cost);
    check("done_pulses", done_cycles - d0, 1);
    check("writes_left", exp_q.size(), 0);
    check("src_never_writes", int'(src_we_seen), 0);
  endtask

  kern_t k_id, k_box, k_127, k_neg, k_lap, k_r1, k_r2;

  initial begin
    k_id  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    k_box = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    k_127 = '{0, 0, 0, 0, 127, 0, 0, 0, 0};
    k_neg = '{0, 0, 0, 0, -1, 0, 0, 0, 0};
    k_lap = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
    rstn   = 1'b1;
    en     = 1'b0;
    nrows  = '0;
    ncols  = '0;
    coeffs = '0;
    shift  = '0;
    #2 rstn = 1'b0;
    #1 check_idle("reset");
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    check_idle("idle");

    fill_ramp(4, 4);
    run_frame(4, 4, k_id, 0, -1, -1);
    fill_const(8, 8, 200);
    run_frame(8, 8, k_box, 3, -1, -1);
    fill_const(5, 5, 255);
    run_frame(5, 5, k_127, 0, -1, -1);
    fill_rand(5, 5);
    run_frame(5, 5, k_neg, 0, -1, -1);
    fill_const(6, 6, 100);
    run_frame(6, 6, k_lap, 0, -1, -1);
    fill_rand(2, 4);
    run_frame(2, 4, k_box, 0, -1, -1);
    run_frame(0, 5, k_id, 0, -1, -1);
    run_frame(5, 1, k_box, 0, -1, -1);

    // en pulsed while busy must not disturb the frame in flight.
    rand_kern(k_r1);
    fill_rand(7, 9);
    run_frame(7, 9, k_r1, $urandom_range(0, 6), 5, -1);

    // Reset in the middle of the first interior READ, then a fresh frame.
    fill_ramp(8, 8);
    run_frame(8, 8, k_id, 0, -1, 12);
    @(posedge clk); #1;
    rand_kern(k_r1);
    fill_rand(6, 7);
    run_frame(6, 7, k_r1, $urandom_range(0, 6), -1, -1);

    // Back-to-back: the second en lands in the IDLE cycle right after done.
    rand_kern(k_r1);
    rand_kern(k_r2);
    fill_rand(5, 6);
    run_frame(5, 6, k_r1, $urandom_range(0, 6), -1, -1);
    run_frame(5, 6, k_r2, $urandom_range(0, 6), -1, -1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/img_conv_engine.md
Name: img_conv_engine

Overview:
- Sits between io_rx_controller and io_tx_controller in the image path.
- After rx has filled the source img_sram, this block reads the image, applies a 3x3 signed-kernel convolution, and writes the result to a second img_sram.
- io_tx_controller then streams the result out.
- It is the master of two img_sram_intf ports: source (read-only use) and destination (write-only use).

Parameters:
- PIX_W, 8, pixel and SRAM data width
- ADDR_W, 8, row/col address width (max image 256x256)
- COEFF_W, 8, signed kernel coefficient width

Ports:
- clk  input  1  system clock (same clk as the img_sram_intf instances)
- rstn  input  1  asynchronous, active-low reset
- en  input  1  start strobe; sampled only in IDLE
- nrows  input  ADDR_W  image rows; latched at start
- ncols  input  ADDR_W  image cols; latched at start
- coeffs  input  9*COEFF_W  kernel, coeff k at bits [8k+7:8k], k=3*dr+dc, dr/dc in 0..2 (0 = row/col -1); latched at start
- shift  input  4  arithmetic right-shift applied to the sum; latched at start
- busy  output  1  high while processing
- done  output  1  one-cycle pulse after last write
- sram_src  interface  img_sram_intf.mst  source image SRAM
- sram_dst  interface  img_sram_intf.mst  destination image SRAM

Behaviour:
- Reset and idle values:
  - busy=0, done=0.
  - Both ports: write_en=0, sense_en=1, row=0, col=0, din=0.
  - State IDLE.
  - Async assert at any time, mid-frame included, returns to these values immediately; partial output is abandoned.
- SRAM read timing: address plus sense_en=1 with write_en=0 in cycle t; dout is valid and captured at the end of cycle t+1.
- SRAM write timing: row/col/din with write_en=1 for one cycle.
- States: IDLE, PIX, READ, DRAIN, WRITE, DONE.
- IDLE:
  - en=1 latches nrows, ncols, coeffs, shift and clears r=c=0.
  - Next state is PIX with busy=1.
  - If nrows==0 or ncols==0, go directly to DONE.
- PIX (zero-width decision, combinational into the next state):
  - Border pixel (r==0, c==0, r==nrows-1 or c==ncols-1) goes to WRITE with value 0.
  - Otherwise go to READ with k=0 and acc=0.
- READ:
  - 9 cycles, k=0..8; issue src address (r-1+dr, c-1+dc).
  - Each returned pixel p (unsigned) is accumulated: acc += signed'({1'b0,p}) * coeff[k] one cycle later.
- DRAIN: 1 cycle; accumulates the k=8 data.
- WRITE:
  - 1 cycle; dst write at (r,c) with data sat(acc >>> shift).
  - sat clamps to 0..255.
  - Advance c; at ncols-1, wrap c to 0 and increment r.
  - After (nrows-1, ncols-1), go to DONE; otherwise go to PIX.
- Accumulator: signed 20 bits (9 products of 17 bits), with no overflow possible.
- Pixel cost:
  - Interior pixel: 11 cycles (READ 9 + DRAIN 1 + WRITE 1).
  - Border pixel: 1 cycle.
  - busy is high for exactly the sum of these cycles.
- DONE: 1 cycle; busy=0, done=1; then back to IDLE.
- en while busy or in DONE is ignored.
- nrows<3 or ncols<3: every pixel is border, so output is all zeros.
- The dst port never asserts write_en during READ/DRAIN. The src port never asserts write_en at all.

Decomposition:
- Package img_conv_pkg:
  - PIX_W, ADDR_W, COEFF_W, ACC_W=20
  - state enum conv_state_t
  - function sat_pix(acc, shift)
- Sub-module img_conv_mac: accumulator with clear, accumulate-enable, signed multiply, and shift/saturate output.
- img_conv_engine holds the FSM, counters and address generation.

Test Plan:
- Identity kernel: center coeff 1, others 0, shift 0; 4x4 ramp 0..15.
  - dst (1,1)=5, (1,2)=6, (2,1)=9, (2,2)=10; all 12 border pixels 0.
  - busy high exactly 56 cycles, done single pulse.
- Box blur: all coeffs 1, shift 3; 8x8 constant 200 image.
  - Interior = 1800>>3 = 225; border 0.
- Saturation:
  - center 127, image 255: interior 255.
  - center -1: interior 0.
  - Laplacian (center 8, neighbours -1) on flat image: interior 0.
- Degenerate sizes:
  - nrows=2, ncols=4: 8 zero writes, busy 8 cycles.
  - nrows=0: no writes, done pulses one cycle after en.
- Robustness:
  - en pulsed mid-frame: ignored, output unchanged.
  - rstn dropped mid-READ: outputs return to reset values immediately.
  - A fresh en after reset completes a correct frame.
- Back-to-back frames: en on the cycle after done, with a different kernel; second frame uses the new kernel and shift.
